// File: rtl/gate_pkg.sv
// Shared gate definitions: mode encoding, bitwise gate function, popcount.
package gate_pkg;

   // Widest operand the helpers handle; callers zero-extend and truncate.
   localparam int unsigned GATE_MAX_W = 64;
   localparam int unsigned MODE_W     = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_AND  = 3'd0,
      MODE_OR   = 3'd1,
      MODE_XOR  = 3'd2,
      MODE_XNOR = 3'd3,
      MODE_NAND = 3'd4,
      MODE_NOR  = 3'd5,
      MODE_NOT  = 3'd6,
      MODE_BUF  = 3'd7
   } gate_mode_e;

   // Bitwise gate selected by mode; b is ignored for NOT and BUF.
   function automatic logic [GATE_MAX_W-1:0] gate_fn(
      input logic [MODE_W-1:0]     mode,
      input logic [GATE_MAX_W-1:0] a,
      input logic [GATE_MAX_W-1:0] b
   );
      logic [GATE_MAX_W-1:0] y;
      y = '0;
      case (mode)
         MODE_AND:  y = a & b;
         MODE_OR:   y = a | b;
         MODE_XOR:  y = a ^ b;
         MODE_XNOR: y = ~(a ^ b);
         MODE_NAND: y = ~(a & b);
         MODE_NOR:  y = ~(a | b);
         MODE_NOT:  y = ~a;
         default:   y = a;
      endcase
      return y;
   endfunction

   // Number of set bits in v.
   function automatic int unsigned popcount(input logic [GATE_MAX_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < int'(GATE_MAX_W); i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/gate_pipe_stage.sv
// Generic valid/ready register slice: one entry, full throughput, no bubbles.
module gate_pipe_stage #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   output logic              o_ready_c,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;

   // Slot can take new data when empty or when it is being drained.
   assign o_ready_c = !r_valid || i_ready;

   // Load on upstream transfer; empty out when drained with nothing new.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_ready_c) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/gate_pipe_unit.sv
// Two-stage pipelined bitwise gate with result flags and transfer counter.
module gate_pipe_unit
   import gate_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 in_mode,
   input  logic [WIDTH-1:0]           in_a,
   input  logic [WIDTH-1:0]           in_b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_y,
   output logic [2:0]                 out_mode,
   output logic                       out_eq,
   output logic                       out_zero,
   output logic [$clog2(WIDTH+1)-1:0] out_pop,
   output logic [CNT_W-1:0]           done_cnt
);

   localparam int unsigned POP_W = $clog2(WIDTH + 1);
   // Stage 1 payload: {mode, eq, y}
   localparam int unsigned S1_W  = MODE_W + 1 + WIDTH;
   // Stage 2 payload: {mode, eq, zero, pop, y}
   localparam int unsigned S2_W  = MODE_W + 3 + POP_W + WIDTH - 1;

   logic [WIDTH-1:0]  w_y1;
   logic              w_eq1;
   logic [S1_W-1:0]   w_s1_in;
   logic [S1_W-1:0]   w_s1_out;
   logic              w_s1_valid;
   logic              w_s1_ready;

   logic [WIDTH-1:0]  w_s1_y;
   logic [MODE_W-1:0] w_s1_mode;
   logic              w_s1_eq;
   logic              w_s1_zero;
   logic [POP_W-1:0]  w_s1_pop;

   logic [S2_W-1:0]   w_s2_in;
   logic [S2_W-1:0]   w_s2_out;
   logic              w_s2_valid;
   logic              w_s2_ready;

   logic [CNT_W-1:0]  r_done_cnt;

   // Gate result and equality for the incoming operands.
   always_comb begin
      w_y1  = WIDTH'(gate_fn(in_mode, GATE_MAX_W'(in_a), GATE_MAX_W'(in_b)));
      w_eq1 = (in_a == in_b);
   end

   assign w_s1_in = {in_mode, w_eq1, w_y1};

   gate_pipe_stage #(
      .DATA_W (S1_W)
   ) u_stage1 (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (in_valid),
      .o_ready_c (w_s1_ready),
      .i_data    (w_s1_in),
      .o_valid   (w_s1_valid),
      .i_ready   (w_s2_ready),
      .o_data    (w_s1_out)
   );

   // Unpack stage 1 and derive the reduction flags for stage 2.
   always_comb begin
      w_s1_y    = w_s1_out[WIDTH-1:0];
      w_s1_eq   = w_s1_out[WIDTH];
      w_s1_mode = w_s1_out[S1_W-1 -: MODE_W];
      w_s1_zero = ~|w_s1_y;
      w_s1_pop  = POP_W'(popcount(GATE_MAX_W'(w_s1_y)));
   end

   assign w_s2_in = {w_s1_mode, w_s1_eq, w_s1_zero, w_s1_pop, w_s1_y};

   gate_pipe_stage #(
      .DATA_W (S2_W)
   ) u_stage2 (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (w_s1_valid),
      .o_ready_c (w_s2_ready),
      .i_data    (w_s2_in),
      .o_valid   (w_s2_valid),
      .i_ready   (out_ready),
      .o_data    (w_s2_out)
   );

   // Count completed output handshakes; wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_done_cnt <= '0;
      end else if (w_s2_valid && out_ready) begin
         r_done_cnt <= r_done_cnt + CNT_W'(1);
      end
   end

   // Ready is held low during reset so nothing is taken while clearing.
   assign in_ready  = w_s1_ready && !rst;

   assign out_valid = w_s2_valid;
   assign out_y     = w_s2_out[WIDTH-1:0];
   assign out_pop   = w_s2_out[WIDTH +: POP_W];
   assign out_zero  = w_s2_out[WIDTH + POP_W];
   assign out_eq    = w_s2_out[WIDTH + POP_W + 1];
   assign out_mode  = w_s2_out[S2_W-1 -: MODE_W];
   assign done_cnt  = r_done_cnt;

endmodule
